// File: rtl/ccff_stream_loader.sv
// Multi-chain ccff bitstream loader: takes words over valid/ready and shifts them onto
// CHAIN_NUM parallel ccff heads. Optional trailer CRC-8 check with CCFF_LOADER_CRC_EN.
module ccff_stream_loader #(
  parameter int CHAIN_NUM = 4,
  parameter int CHAIN_LEN = 1024,
  parameter int WORD_W    = 32,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic                 prog_clk,
  input  logic                 pReset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [WORD_W-1:0]    bs_data,
  input  logic                 bs_valid,
  output logic                 bs_ready,
  output logic [CHAIN_NUM-1:0] ccff_head,
  output logic                 ccff_shift_en,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     bit_cnt
`ifdef CCFF_LOADER_CRC_EN
  ,
  output logic                 crc_err
`endif
);

  // CHAIN_NUM must divide WORD_W; each word yields SLICES shift cycles.
  localparam int SLICES = WORD_W / CHAIN_NUM;
  localparam int SLC_W  = $clog2(SLICES + 1);
  localparam logic [CNT_W-1:0] LEN_CNT    = CNT_W'(CHAIN_LEN);
  localparam logic [SLC_W-1:0] LAST_SLICE = SLC_W'(SLICES);

`ifdef CCFF_LOADER_CRC_EN
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_CHECK, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;
`endif

  state_t               state_reg, state_next;
  logic [WORD_W-1:0]    hold_reg, hold_next;
  logic [SLC_W-1:0]     slice_reg, slice_next;
  logic [CHAIN_NUM-1:0] head_reg, head_next;
  logic [CNT_W-1:0]     bit_cnt_reg, bit_cnt_next;
  logic                 ready_reg, shift_en_reg, busy_reg, done_reg;
  logic                 ready_next, busy_next;
  logic                 start_ok;

  assign start_ok = (state_reg == S_IDLE || state_reg == S_DONE) && start && !abort;

  always_comb begin
    state_next   = state_reg;
    hold_next    = hold_reg;
    slice_next   = slice_reg;
    head_next    = '0;
    bit_cnt_next = bit_cnt_reg;

    // Every SHIFT cycle is a real chain capture, even if abort arrives with it.
    if (state_reg == S_SHIFT && bit_cnt_reg != LEN_CNT)
      bit_cnt_next = bit_cnt_reg + 1'b1;

    case (state_reg)
      S_IDLE, S_DONE: begin
        if (abort) begin
          state_next = S_IDLE;
        end else if (start) begin
          state_next   = S_LOAD;
          bit_cnt_next = '0;
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_next = S_IDLE;
        end else if (bs_valid) begin
          state_next = S_SHIFT;
          head_next  = bs_data[CHAIN_NUM-1:0];
          hold_next  = bs_data >> CHAIN_NUM;
          slice_next = SLC_W'(1);
        end
      end
      S_SHIFT: begin
        if (abort) begin
          state_next = S_IDLE;
        end else if (bit_cnt_next == LEN_CNT) begin
`ifdef CCFF_LOADER_CRC_EN
          state_next = S_CHECK;
`else
          state_next = S_DONE;
`endif
        end else if (slice_reg == LAST_SLICE) begin
          state_next = S_LOAD;
        end else begin
          head_next  = hold_reg[CHAIN_NUM-1:0];
          hold_next  = hold_reg >> CHAIN_NUM;
          slice_next = slice_reg + 1'b1;
        end
      end
`ifdef CCFF_LOADER_CRC_EN
      S_CHECK: begin
        if (abort)
          state_next = S_IDLE;
        else if (bs_valid)
          state_next = S_DONE;
      end
`endif
      default: state_next = S_IDLE;
    endcase

`ifdef CCFF_LOADER_CRC_EN
    ready_next = (state_next == S_LOAD) || (state_next == S_CHECK);
    busy_next  = (state_next == S_LOAD) || (state_next == S_SHIFT) || (state_next == S_CHECK);
`else
    ready_next = (state_next == S_LOAD);
    busy_next  = (state_next == S_LOAD) || (state_next == S_SHIFT);
`endif
  end

  // Outputs are registered from the next-state decode so they change with the state.
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state_reg    <= S_IDLE;
      hold_reg     <= '0;
      slice_reg    <= '0;
      head_reg     <= '0;
      bit_cnt_reg  <= '0;
      ready_reg    <= 1'b0;
      shift_en_reg <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      hold_reg     <= hold_next;
      slice_reg    <= slice_next;
      head_reg     <= head_next;
      bit_cnt_reg  <= bit_cnt_next;
      ready_reg    <= ready_next;
      shift_en_reg <= (state_next == S_SHIFT);
      busy_reg     <= busy_next;
      done_reg     <= (state_next == S_DONE);
    end
  end

  assign bs_ready      = ready_reg;
  assign ccff_head     = head_reg;
  assign ccff_shift_en = shift_en_reg;
  assign busy          = busy_reg;
  assign done          = done_reg;
  assign bit_cnt       = bit_cnt_reg;

`ifdef CCFF_LOADER_CRC_EN
  logic [7:0] crc_reg;
  logic       crc_err_reg;
  logic [7:0] crc_stage [CHAIN_NUM+1];

  // CRC-8 (poly 0x07), MSB-first, chain 0 bit folded in first each cycle.
  assign crc_stage[0] = crc_reg;
  genvar gi;
  for (gi = 0; gi < CHAIN_NUM; gi++) begin : g_crc
    assign crc_stage[gi+1] = {crc_stage[gi][6:0], 1'b0} ^
                             ((crc_stage[gi][7] ^ head_reg[gi]) ? 8'h07 : 8'h00);
  end

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      crc_reg     <= '0;
      crc_err_reg <= 1'b0;
    end else if (start_ok) begin
      crc_reg     <= '0;
      crc_err_reg <= 1'b0;
    end else begin
      if (state_reg == S_SHIFT)
        crc_reg <= crc_stage[CHAIN_NUM];
      if (state_reg == S_CHECK && !abort && bs_valid)
        crc_err_reg <= (bs_data[7:0] != crc_reg);
    end
  end

  assign crc_err = crc_err_reg;
`endif

endmodule

// File: tb/tb_ccff_stream_loader.sv
// Bench for ccff_stream_loader: two instances (CHAIN_LEN 16 and 10) share stimulus and are
// compared every cycle against a word/slice-level model; directed loads pin the model.
module tb_ccff_stream_loader;
  localparam int CN = 4, WW = 32, WPC = WW / CN;
  localparam int LEN_A = 16, LEN_B = 10;
`ifdef CCFF_LOADER_CRC_EN
  localparam int DONE_LAT = 2;
`else
  localparam int DONE_LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst, start, abort, bs_valid;
  logic [31:0] bs_data;
  logic ready_a, sh_a, busy_a, done_a, ready_b, sh_b, busy_b, done_b;
  logic [3:0] head_a, head_b;
  logic [4:0] cnt_a;
  logic [3:0] cnt_b;
`ifdef CCFF_LOADER_CRC_EN
  logic err_a, err_b;
`endif

  always #5 clk = ~clk;

  ccff_stream_loader #(.CHAIN_NUM(CN), .CHAIN_LEN(LEN_A), .WORD_W(WW)) dut_a (
    .prog_clk(clk), .pReset(rst), .start(start), .abort(abort),
    .bs_data(bs_data), .bs_valid(bs_valid), .bs_ready(ready_a),
    .ccff_head(head_a), .ccff_shift_en(sh_a), .busy(busy_a), .done(done_a),
    .bit_cnt(cnt_a)
`ifdef CCFF_LOADER_CRC_EN
    , .crc_err(err_a)
`endif
  );

  ccff_stream_loader #(.CHAIN_NUM(CN), .CHAIN_LEN(LEN_B), .WORD_W(WW)) dut_b (
    .prog_clk(clk), .pReset(rst), .start(start), .abort(abort),
    .bs_data(bs_data), .bs_valid(bs_valid), .bs_ready(ready_b),
    .ccff_head(head_b), .ccff_shift_en(sh_b), .busy(busy_b), .done(done_b),
    .bit_cnt(cnt_b)
`ifdef CCFF_LOADER_CRC_EN
    , .crc_err(err_b)
`endif
  );

  int vectors = 0;
  int miscompares = 0;
  bit cmp_on = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  // Model: a load is the concatenated accepted words; shift s presents slice s of that
  // stream, a word is requested whenever the stream runs dry, and it ends at LEN shifts.
  logic        m_ready[2], m_shift[2], m_busy[2], m_done[2], m_chk[2], m_err[2];
  logic [3:0]  m_head[2];
  logic [7:0]  m_crc[2];
  logic [31:0] m_words[2][4];
  int          m_cnt[2], m_nw[2];

  function automatic logic [7:0] crc8_nibble(input logic [7:0] c, input logic [3:0] d);
    logic [7:0] r;
    r = c;
    for (int k = 0; k < 4; k++)
      r = (r[7] ^ d[k]) ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction

  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      int len, cn;
      bit shifted, step;
      len = (u == 0) ? LEN_A : LEN_B;
      shifted = m_shift[u];
      cn = m_cnt[u] + ((shifted && m_cnt[u] < len) ? 1 : 0);
      if (shifted) m_crc[u] = crc8_nibble(m_crc[u], m_head[u]);
      step = 1'b0;
      if (rst) begin
        m_ready[u] = 0; m_shift[u] = 0; m_busy[u] = 0; m_done[u] = 0; m_chk[u] = 0;
        m_err[u] = 0; m_head[u] = 0; m_crc[u] = 0; m_cnt[u] = 0; m_nw[u] = 0;
      end else if (abort) begin
        m_ready[u] = 0; m_shift[u] = 0; m_busy[u] = 0; m_done[u] = 0; m_chk[u] = 0;
        m_head[u] = 0; m_cnt[u] = cn;
      end else if (!m_busy[u] && start) begin
        m_ready[u] = 1; m_shift[u] = 0; m_busy[u] = 1; m_done[u] = 0; m_chk[u] = 0;
        m_err[u] = 0; m_head[u] = 0; m_crc[u] = 0; m_cnt[u] = 0; m_nw[u] = 0;
      end else if (m_busy[u]) begin
        m_cnt[u] = cn;
        if (m_ready[u] && bs_valid && m_chk[u]) begin
          m_err[u] = (bs_data[7:0] != m_crc[u]);
          m_chk[u] = 0; m_ready[u] = 0; m_busy[u] = 0; m_done[u] = 1;
        end else if (m_ready[u] && bs_valid) begin
          if (m_nw[u] < 4) m_words[u][m_nw[u]] = bs_data;
          m_nw[u]++;
          step = 1'b1;
        end else if (shifted) begin
          step = 1'b1;
        end
        if (step) begin
          m_ready[u] = 0; m_shift[u] = 0; m_head[u] = 0;
          if (cn == len) begin
`ifdef CCFF_LOADER_CRC_EN
            m_chk[u] = 1; m_ready[u] = 1;
`else
            m_busy[u] = 0; m_done[u] = 1;
`endif
          end else if (cn < m_nw[u] * WPC) begin
            m_shift[u] = 1;
            m_head[u] = 4'(m_words[u][cn / WPC] >> (CN * (cn % WPC)));
          end else begin
            m_ready[u] = 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("a_ready", ready_a, m_ready[0]);  chk("b_ready", ready_b, m_ready[1]);
      chk("a_shift", sh_a, m_shift[0]);     chk("b_shift", sh_b, m_shift[1]);
      chk("a_busy", busy_a, m_busy[0]);     chk("b_busy", busy_b, m_busy[1]);
      chk("a_done", done_a, m_done[0]);     chk("b_done", done_b, m_done[1]);
      chk("a_bitcnt", cnt_a, m_cnt[0]);     chk("b_bitcnt", cnt_b, m_cnt[1]);
      if (m_shift[0]) chk("a_head", head_a, m_head[0]);
      if (m_shift[1]) chk("b_head", head_b, m_head[1]);
`ifdef CCFF_LOADER_CRC_EN
      chk("a_crc_err", err_a, m_err[0]);   chk("b_crc_err", err_b, m_err[1]);
`endif
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int i;
    for (i = 0; i < 200 && (busy_a || busy_b); i++) @(negedge clk);
    chk(nm, busy_a | busy_b, 0);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_ready"}, ready_a, 0); chk({nm, "_shift"}, sh_a, 0);
    chk({nm, "_head"}, head_a, 0);   chk({nm, "_busy"}, busy_a, 0);
    chk({nm, "_done"}, done_a, 0);   chk({nm, "_bitcnt"}, cnt_a, 0);
`ifdef CCFF_LOADER_CRC_EN
    chk({nm, "_crc_err"}, err_a, 0);
`endif
  endtask

  initial begin
    logic [31:0] wl [2];
    logic [3:0]  ha [16];
    logic [3:0]  hb [16];
    int shcyc[16];
    int w, ns_a, ns_b, done_at, nacc_b;
    bit acc_pend;

    rst = 1'b1; start = 0; abort = 0; bs_valid = 0; bs_data = '0;
    @(negedge clk);
    cmp_on = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_reset_vals("reset");

    // Basic load (A: 16 shifts) and partial final word (B: 10 shifts) on the same words.
    wl[0] = 32'h7654_3210; wl[1] = 32'hFEDC_BA98;
    bs_valid = 1'b1; bs_data = wl[0];
    pulse_start();
    w = 0; ns_a = 0; ns_b = 0; done_at = -1; nacc_b = 0; acc_pend = 0;
    for (int c = 0; c < 40 && done_at < 0; c++) begin
      if (acc_pend && w < 1) w++;
      bs_data = wl[w];
      acc_pend = ready_a;
      start = (c == 4);
      if (sh_a) begin
        if (ns_a < 16) begin ha[ns_a] = head_a; shcyc[ns_a] = c; end
        ns_a++;
      end
      if (sh_b) begin
        if (ns_b < 16) hb[ns_b] = head_b;
        ns_b++;
      end
      if (ready_b && cnt_b < 4'(LEN_B)) nacc_b++;
      if (done_a) done_at = c;
      @(negedge clk);
    end
    start = 1'b0;
    chk("basic_nshift", ns_a, 16);
    chk("basic_done_seen", (done_at >= 0) ? 1 : 0, 1);
    for (int i = 0; i < 16 && i < ns_a; i++) chk("basic_head", ha[i], i);
    if (ns_a >= 16) begin
      chk("basic_first8_contig", shcyc[7] - shcyc[0], 7);
      chk("basic_bubble", shcyc[8] - shcyc[7], 2);
      chk("basic_done_lat", done_at - shcyc[15], DONE_LAT);
    end
    chk("basic_bitcnt", cnt_a, 16);
    chk("part_nshift", ns_b, 10);
    chk("part_words", nacc_b, 2);
    for (int i = 0; i < 10 && i < ns_b; i++) chk("part_head", hb[i], i);
    chk("part_done", done_b, 1);

    // Backpressure: no word for 5 LOAD cycles.
    bs_valid = 1'b0;
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      chk("bp_shift", sh_a, 0); chk("bp_bitcnt", cnt_a, 0); chk("bp_ready", ready_a, 1);
      @(negedge clk);
    end
    bs_valid = 1'b1; bs_data = $urandom;
    @(negedge clk);
    chk("bp_resume", sh_a, 1);
    wait_idle("bp_timeout");

    // Synchronous reset mid-load, then a clean reload.
    pulse_start();
    for (int i = 0; i < 40 && cnt_a != 5'd5; i++) begin bs_data = $urandom; @(negedge clk); end
    chk("rst_reach5", cnt_a, 5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_vals("midrst");
    pulse_start();
    chk("reload_bitcnt", cnt_a, 0); chk("reload_busy", busy_a, 1);
    wait_idle("reload_timeout");

    // Abort at bit_cnt 7 with a concurrent start, then abort+start while idle.
    pulse_start();
    for (int i = 0; i < 40 && cnt_a != 5'd7; i++) @(negedge clk);
    chk("abort_reach7", cnt_a, 7);
    abort = 1'b1; start = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    chk("abort_busy", busy_a, 0); chk("abort_done", done_a, 0); chk("abort_shift", sh_a, 0);
    abort = 1'b1; start = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    chk("abort_wins", busy_a, 0);

`ifdef CCFF_LOADER_CRC_EN
    // All-zero bitstream: CRC is 0x00, so trailer 0 passes and trailer 1 fails.
    for (int t = 0; t < 2; t++) begin
      bs_data = '0;
      pulse_start();
      for (int i = 0; i < 60 && !done_a; i++) begin
        bs_data = (ready_a && cnt_a == 5'(LEN_A)) ? 32'(t) : 32'h0;
        @(negedge clk);
      end
      chk("crc_model_zero", m_crc[0], 0);
      chk("crc_done", done_a, 1);
      chk("crc_err", err_a, t);
    end
`endif

    // Randomized traffic with occasional abort and reset.
    for (int c = 0; c < 3000; c++) begin
      start    = ($urandom % 6) == 0;
      abort    = ($urandom % 150) == 0;
      rst      = ($urandom % 400) == 0;
      bs_valid = ($urandom % 3) != 0;
      bs_data  = $urandom;
      @(negedge clk);
    end
    start = 0; abort = 0; rst = 0; bs_valid = 0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
